// File: rtl/hm_pkg.sv
// Shared definitions for the HM memory reader slice.
//   HM_MEM_BYTES / HM_ADDR_SHIFT : geometry of the HM byte memory and how a
//                                   byte index maps onto the 16-bit port address
//   hm_state_e                   : reader control states
//   hm_word_t                    : one buffered output word with its last tag
//   hm_mem_addr()                : byte index -> port address
package hm_pkg;

    localparam int unsigned HM_MEM_BYTES  = 4096;
    localparam int unsigned HM_ADDR_SHIFT = 3;
    localparam int unsigned HM_IDX_W      = $clog2(HM_MEM_BYTES);
    localparam int unsigned HM_WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } hm_state_e;

    typedef struct packed {
        logic                 last;
        logic [HM_WORD_W-1:0] data;
    } hm_word_t;

    // Port address is {1'b0, byte_idx[11:0], 3'b000}.
    function automatic logic [15:0] hm_mem_addr(input logic [HM_IDX_W-1:0] idx);
        return 16'(idx) << HM_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/hm_stream_fifo.sv
// Small synchronous FIFO buffering read words ({last, data}) for the output
// stream. Head entry is presented combinationally on rd_data.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   push, wr_data    : write one entry
//   pop              : remove the head entry (caller guarantees count != 0)
//   rd_data          : current head entry
//   count            : number of valid entries
// Simultaneous push and pop leave count unchanged.
module hm_stream_fifo
    import hm_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       push,
    input  hm_word_t                   wr_data,
    input  logic                       pop,
    output hm_word_t                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    hm_word_t           store [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= wr_data;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = store[rd_ptr];

endmodule

// File: rtl/hm_memory_reader.sv
// Sequential read initiator for one port of the HM dual-port byte memory.
// Takes a (start byte index, word count) command, issues back-to-back port
// reads and returns the words on a valid/ready stream with a last flag.
//   sys_clk, sys_rst           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake
//   cmd_addr, cmd_len          : start byte index, number of 32-bit words
//   mem_addr/mem_we/mem_di     : port drive (read only, write side tied off)
//   mem_do                     : read data, valid the cycle after mem_addr
//   data_valid/data_ready      : output stream handshake
//   data, data_last            : output word, final-word flag
//   busy, done                 : command in progress, completion pulse
module hm_memory_reader
    import hm_pkg::*;
#(
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [11:0]          cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic [15:0]          mem_addr,
    output logic [3:0]           mem_we,
    output logic [31:0]          mem_di,
    input  logic [31:0]          mem_do,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic [31:0]          data,
    output logic                 data_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    hm_state_e             state;
    hm_state_e             state_nx;
    logic [HM_IDX_W-1:0]   byte_idx;
    logic [LEN_W-1:0]      remaining;
    logic                  inflight;
    logic                  inflight_last;
    logic                  cmd_ready_q;

    logic                  accept;
    logic                  issue;
    logic                  credit_ok;
    logic                  fifo_pop;
    logic [CNT_W-1:0]      fifo_count;
    hm_word_t              fifo_head;
    hm_word_t              fifo_in;

    // A word leaving the FIFO this cycle frees its slot for the read issued
    // now; counting it keeps full throughput with a 2-entry buffer while
    // count + inflight still never exceeds FIFO_DEPTH.
    assign credit_ok = (32'(fifo_count) + 32'(inflight)) < (FIFO_DEPTH + 32'(fifo_pop));

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept   = 1'b1;
                    state_nx = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (remaining == '0) begin
                    state_nx = ST_DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Everything has been issued; finish once the final word
                // has left (or is leaving) the buffer.
                if (!inflight &&
                    ((fifo_count == '0) || (fifo_count == CNT_W'(1) && fifo_pop))) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            byte_idx      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nx;
            // Registered so cmd_ready is low in reset and rises one cycle later.
            cmd_ready_q   <= (state_nx == ST_IDLE);
            inflight      <= issue;
            inflight_last <= issue && (remaining == LEN_W'(1));
            if (accept) begin
                byte_idx  <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                byte_idx  <= byte_idx + HM_IDX_W'(4);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    assign fifo_in.last = inflight_last;
    assign fifo_in.data = mem_do;

    hm_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (inflight),
        .wr_data (fifo_in),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifo_count)
    );

    assign data_valid = (fifo_count != '0);
    assign fifo_pop   = data_valid && data_ready;
    assign data       = fifo_head.data;
    assign data_last  = fifo_head.last;

    assign cmd_ready  = cmd_ready_q;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign mem_addr   = hm_mem_addr(byte_idx);
    assign mem_we     = '0;
    assign mem_di     = '0;

endmodule

// File: tb/tb_hm_memory_reader.sv
// Bench for hm_memory_reader: a behavioural HM memory drives mem_do, and each
// command's expected word list is computed up front from the byte array.
module tb_hm_memory_reader;

    localparam int unsigned LEN_W = 11;

    logic              sys_clk;
    logic              sys_rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [11:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [15:0]       mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_di;
    logic [31:0]       mem_do;
    logic              data_valid;
    logic              data_ready;
    logic [31:0]       data;
    logic              data_last;
    logic              busy;
    logic              done;

    logic [7:0]        mem [4096];
    int                n_cmp;
    int                n_bad;

    hm_memory_reader #(
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_di     (mem_di),
        .mem_do     (mem_do),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .data_last  (data_last),
        .busy       (busy),
        .done       (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Little-endian 32-bit word at an aligned byte index.
    function automatic logic [31:0] word_at(input logic [11:0] idx);
        logic [11:0] b;
        b = {idx[11:2], 2'b00};
        return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
    endfunction

    // HM memory: synchronous 1-cycle read
    always @(posedge sys_clk) mem_do <= word_at(mem_addr[14:3]);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},  64'(cmd_ready),  64'(0));
        check({tag, "_data_valid"}, 64'(data_valid), 64'(0));
        check({tag, "_data"},       64'(data),       64'(0));
        check({tag, "_data_last"},  64'(data_last),  64'(0));
        check({tag, "_busy"},       64'(busy),       64'(0));
        check({tag, "_done"},       64'(done),       64'(0));
        check({tag, "_mem_addr"},   64'(mem_addr),   64'(0));
    endtask

    // rmode: 0 = ready always, 1 = ready pattern 1,0,0, 2 = random ready
    task automatic run_cmd(input logic [11:0] addr, input int unsigned len, input int unsigned rmode);
        logic [32:0]  exp_q[$];
        logic [32:0]  e;
        logic [31:0]  held_data;
        logic         held_last;
        logic         stalled;
        int unsigned  w;
        int unsigned  budget;
        int           done_t;
        int           first_t;
        bit           finished;

        for (int unsigned k = 0; k < len; k++) begin
            exp_q.push_back({(k == len - 1), word_at(12'(32'(addr) + 4 * k))});
        end

        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge sys_clk); #1;
            w++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;

        budget   = 4 * len + 20;
        done_t   = -1;
        first_t  = -1;
        stalled  = 1'b0;
        finished = 1'b0;
        held_data = '0;
        held_last = 1'b0;

        for (int t = 0; t < int'(budget); t++) begin
            if (t > 0) begin
                @(posedge sys_clk); #1;
            end
            case (rmode)
                0:       data_ready = 1'b1;
                1:       data_ready = (t % 3 == 0);
                default: data_ready = 1'($urandom_range(0, 1));
            endcase

            if (t == 0) begin
                check("busy_after_accept",  64'(busy),      64'(1));
                check("cmd_ready_low",      64'(cmd_ready), 64'(0));
                check("first_mem_addr",     64'(mem_addr),  64'(32'(addr) * 8));
                check("mem_we_zero",        64'(mem_we),    64'(0));
                check("mem_di_zero",        64'(mem_di),    64'(0));
            end
            if (t == 1 && len >= 2) begin
                check("second_mem_addr", 64'(mem_addr), 64'(((32'(addr) + 4) % 4096) * 8));
            end

            if (stalled) begin
                check("stall_valid_held", 64'(data_valid), 64'(1));
                check("stall_data_held",  64'(data),       64'(held_data));
                check("stall_last_held",  64'(data_last),  64'(held_last));
            end
            if (data_valid && first_t < 0) first_t = t;
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(data),      64'(e[31:0]));
                    check("last", 64'(data_last), 64'(e[32]));
                end
            end
            stalled   = data_valid && !data_ready;
            held_data = data;
            held_last = data_last;

            if (done_t >= 0 && t == done_t + 1) begin
                check("done_single_pulse", 64'(done),      64'(0));
                check("idle_busy",         64'(busy),      64'(0));
                check("idle_cmd_ready",    64'(cmd_ready), 64'(1));
                finished = 1'b1;
                break;
            end
            if (done && done_t < 0) begin
                done_t = t;
                check("done_after_last_word", 64'(exp_q.size()), 64'(0));
                check("busy_with_done",       64'(busy),          64'(1));
            end
        end

        check("cmd_completed", 64'(finished), 64'(1));
        check("words_missing", 64'(exp_q.size()), 64'(0));
        if (rmode == 0) begin
            check("done_latency", 64'(done_t), 64'((len == 0) ? 0 : len + 2));
            if (len > 0) check("first_valid_latency", 64'(first_t), 64'(2));
            else         check("no_valid_len0",       64'(first_t), 64'(-1));
        end
        data_ready = 1'b0;
    endtask

    initial begin
        int unsigned got;
        int unsigned w;

        n_cmp      = 0;
        n_bad      = 0;
        sys_rst    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        data_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

        #1;
        check_reset_outputs("reset");
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        run_cmd(12'h000, 1, 0);
        run_cmd(12'h004, 3, 0);
        run_cmd(12'hFFC, 2, 0);
        run_cmd(12'h010, 8, 1);
        run_cmd(12'h020, 0, 0);

        // Reset in the middle of an 8-word read
        cmd_addr   = 12'h010;
        cmd_len    = LEN_W'(8);
        cmd_valid  = 1'b1;
        data_ready = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge sys_clk); #1;
            w++;
        end
        check("rst_cmd_ready_wait", 64'(cmd_ready), 64'(1));
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        got = 0;
        w   = 0;
        while (got < 3 && w < 30) begin
            @(posedge sys_clk); #1;
            if (data_valid && data_ready) got++;
            w++;
        end
        check("rst_three_words_seen", 64'(got), 64'(3));
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge sys_clk); #1;
        check_reset_outputs("held_reset");
        @(negedge sys_clk);
        sys_rst    = 1'b0;
        data_ready = 1'b0;
        run_cmd(12'h000, 1, 0);

        // Random memory contents, commands and back-pressure
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 12; n++) begin
            run_cmd(12'($urandom) & 12'hFFC, $urandom_range(0, 20), 2);
        end
        run_cmd(12'hFF0, 9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hm_memory_reader.md
Name: hm_memory_reader

Overview:
- Sequential read initiator for one port of the 32-bit dual-port HM byte memory (4096 bytes, byte-lane write enables, 1-cycle synchronous read).
- Accepts a (start byte index, word count) command and issues back-to-back port reads.
- Returns the words on a valid/ready stream with a last flag.
- Sits between the HM memory port B and the dump/export path that ships memory contents to the host.

Parameters:
- LEN_W, 11, width of the word-count field (max 1024 words = whole memory).
- FIFO_DEPTH, 2, output buffer entries; fixed at 2, the minimum for full throughput with 1-cycle read latency.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  12  start byte index.
- cmd_len  in  LEN_W  number of 32-bit words to read.
- mem_addr  out  16  port address = {1'b0, byte_idx[11:0], 3'b000}.
- mem_we  out  4  write enables, constant 4'b0000.
- mem_di  out  32  write data, constant 0.
- mem_do  in  32  read data, valid the cycle after mem_addr is presented.
- data_valid  out  1  output word valid.
- data_ready  in  1  sink accepts the word.
- data  out  32  read word.
- data_last  out  1  final word of the command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the final word is accepted, or on completion of a len-0 command.

Behaviour:
- Reset values: cmd_ready=0, data_valid=0, data=0, data_last=0, busy=0, done=0, mem_addr=0, FIFO empty, state IDLE. Reset is asynchronous and may arrive at any point; it aborts the command and discards buffered words.
- States:
  - IDLE: cmd_ready=1. On accept, latch byte_idx=cmd_addr and remaining=cmd_len. If cmd_len==0, go to DONE. Otherwise go to RUN.
  - RUN: issue a read when remaining!=0 and (fifo_count + inflight) < 2. On each issue, byte_idx += 4 (12-bit, wraps 0xFFC -> 0x000) and remaining -= 1. When remaining==0, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and the last word is accepted, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. cmd_ready=0 in RUN, DRAIN and DONE.
- Read pipeline:
  - inflight flag set in the issue cycle.
  - Next cycle, mem_do is pushed to the FIFO and tagged last when it is the final issued word.
- Latency: first data_valid is 2 cycles after command accept (issue +1, capture +1). With data_ready held high, throughput is 1 word/cycle.
- Stream rules:
  - data, data_last stable while data_valid & !data_ready.
  - No word dropped or duplicated.
  - data_last=1 only on the final word.
- Simultaneous push and pop in one cycle is legal: count is unchanged.
- The credit rule guarantees the FIFO never overflows, so no overflow condition exists.
- busy=1 from accept until the cycle done asserts, inclusive.
- A cmd_valid arriving while busy is ignored; the requester holds it until cmd_ready.

Decomposition:
- Shared package hm_pkg holds:
  - HM_MEM_BYTES=4096 and HM_ADDR_SHIFT=3.
  - State encodings (IDLE, RUN, DRAIN, DONE).
  - A function forming mem_addr from a byte index.
- One natural sub-module: hm_stream_fifo, a 2-entry synchronous FIFO of {last, data[31:0]} with count, push/pop and asynchronous reset.

Test Plan:
- Memory preloaded with mem[d]=d[7:0]; cmd_addr=0x000, len=1, ready=1 -> one word 0x03020100 with last=1, 2 cycles after accept; done 1 cycle later.
- cmd_addr=0x004, len=3, ready=1 -> 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles; last only on the third word.
- cmd_addr=0xFFC, len=2 -> 0xFFFEFDFC then 0x03020100 (index wrap); second mem_addr=0x0000.
- cmd_addr=0x010, len=8, data_ready toggling 1,0,0,1,... -> exactly the 8 words 0x13121110..0x2F2E2D2C in order; data held stable while stalled; FIFO count never exceeds 2.
- cmd_len=0 -> no data_valid; done pulses; cmd_ready back to 1 within 2 cycles.
- sys_rst asserted mid-RUN (after 3 of 8 words) -> all outputs return to reset values asynchronously. A new command after release starts cleanly: cmd_addr=0, len=1 -> 0x03020100.
